// File: rtl/gauss_sample_reader.sv
// Box-Muller consumer: buffers (cos, sin) pairs in a FIFO and serialises them
// as one valid/ready sample stream, cos first, dropping pairs that find the FIFO full.
module gauss_sample_reader #(
    parameter int N_RES  = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_val,
    input  logic [N_RES-1:0]  in_cos,
    input  logic [N_RES-1:0]  in_sin,
    output logic [N_RES-1:0]  out_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic              out_sel,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              clr_drop,
    output logic [1:0]        fsm_state
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        SEND_COS = 2'd1,
        SEND_SIN = 2'd2
    } state_t;

    logic [2*N_RES-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    level_q;

    logic               push;
    logic               drop;
    logic               pop;
    logic [N_RES-1:0]   head_cos;
    logic [N_RES-1:0]   head_sin;

    state_t             state;
    state_t             state_nx;
    logic [N_RES-1:0]   pc;
    logic [N_RES-1:0]   ps;
    logic [N_RES-1:0]   pc_nx;
    logic [N_RES-1:0]   ps_nx;
    logic [N_RES-1:0]   data_nx;
    logic               val_nx;
    logic               sel_nx;

    assign level     = level_q;
    assign full      = (level_q == DEPTH_L);
    assign empty     = (level_q == '0);
    assign fsm_state = state;

    // full is the registered occupancy, so a same-cycle pop never rescues an incoming pair.
    assign push = in_val & ~full;
    assign drop = in_val & full;

    assign {head_cos, head_sin} = mem[rd_ptr];

    // Storage is deliberately unreset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_cos, in_sin};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (clr_drop) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

    // Output handshake: a sample transfers on a rising edge where out_val and out_rdy are
    // both high; while out_val=1 and out_rdy=0 the sample (out_data, out_sel) is held unchanged.
    // After EMPTY the popped pair spends one cycle in {pc,ps} before out_val rises.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        pc_nx    = pc;
        ps_nx    = ps;
        val_nx   = out_val;
        data_nx  = out_data;
        sel_nx   = out_sel;
        case (state)
            EMPTY: begin
                if (!empty) begin
                    pop      = 1'b1;
                    pc_nx    = head_cos;
                    ps_nx    = head_sin;
                    state_nx = SEND_COS;
                end
            end
            SEND_COS: begin
                if (!out_val) begin
                    val_nx  = 1'b1;
                    data_nx = pc;
                    sel_nx  = 1'b0;
                end else if (out_rdy) begin
                    data_nx  = ps;
                    sel_nx   = 1'b1;
                    state_nx = SEND_SIN;
                end
            end
            SEND_SIN: begin
                if (out_rdy) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        pc_nx    = head_cos;
                        ps_nx    = head_sin;
                        data_nx  = head_cos;
                        sel_nx   = 1'b0;
                        state_nx = SEND_COS;
                    end else begin
                        val_nx   = 1'b0;
                        state_nx = EMPTY;
                    end
                end
            end
            default: begin
                val_nx   = 1'b0;
                state_nx = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            pc       <= '0;
            ps       <= '0;
            out_val  <= 1'b0;
            out_data <= '0;
            out_sel  <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ps       <= ps_nx;
            out_val  <= val_nx;
            out_data <= data_nx;
            out_sel  <= sel_nx;
        end
    end

endmodule

// File: tb/tb_gauss_sample_reader.sv
// Bench for gauss_sample_reader: directed pair streams against a queue model of the sample
// stream and drop counter, plus literal latency/occupancy/reset expectations.
module tb_gauss_sample_reader;

    localparam int N_RES  = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_val = 1'b0;
    logic [N_RES-1:0]  in_cos = '0;
    logic [N_RES-1:0]  in_sin = '0;
    logic [N_RES-1:0]  out_data;
    logic              out_val;
    logic              out_rdy = 1'b1;
    logic              out_sel;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic [CNT_W-1:0]  drop_cnt;
    logic              clr_drop = 1'b0;
    logic [1:0]        fsm_state;

    gauss_sample_reader #(.N_RES(N_RES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_cos(in_cos), .in_sin(in_sin),
        .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy), .out_sel(out_sel),
        .full(full), .empty(empty), .level(level), .drop_cnt(drop_cnt),
        .clr_drop(clr_drop), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    int               n_acc    = 0;
    logic [N_RES:0]   exp_q[$];          // {sel, data} in expected output order
    logic [CNT_W-1:0] model_drop = '0;
    logic             rdy_rand = 1'b0;
    logic             prev_stall = 1'b0;
    logic [N_RES-1:0] prev_data = '0;
    logic             prev_sel = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: one clock of input; model is updated at the edge that samples the inputs
    task automatic step(input logic v, input logic [N_RES-1:0] c, input logic [N_RES-1:0] s,
                        input logic exp_drop, input logic clr);
        in_val   = v;
        in_cos   = c;
        in_sin   = s;
        clr_drop = clr;
        if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (clr) model_drop = '0;
        else if (v && exp_drop && model_drop != '1) model_drop = model_drop + CNT_W'(1);
        if (v && !exp_drop) begin
            exp_q.push_back({1'b0, c});
            exp_q.push_back({1'b1, s});
        end
        #1;
        in_val   = 1'b0;
        clr_drop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_val) && k < 400) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
            k++;
        end
        chk("drain_done", 64'(exp_q.size() == 0 && !out_val), 64'd1);
    endtask

    // scoreboard / compare process, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("empty_rule", empty, 64'(level == 0));
            chk("full_rule", full, 64'(level == 16));
            chk("level_max", 64'(level <= 16), 64'd1);
            chk("drop_cnt", drop_cnt, model_drop);
            if (prev_stall) begin
                chk("stall_val", out_val, 64'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_sel", out_sel, prev_sel);
            end
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", out_data, 64'hDEAD);
                end else begin
                    logic [N_RES:0] e;
                    e = exp_q.pop_front();
                    chk("sample_data", out_data, e[N_RES-1:0]);
                    chk("sample_sel", out_sel, e[N_RES]);
                end
                n_acc++;
            end
            prev_stall = out_val && !out_rdy;
            prev_data  = out_data;
            prev_sel   = out_sel;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;

        // reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_out_val", out_val, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sel", out_sel, 64'd0);
        chk("rst_level", level, 64'd0);
        chk("rst_empty", empty, 64'd1);
        chk("rst_full", full, 64'd0);
        chk("rst_drop_cnt", drop_cnt, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // single pair, two-cycle latency
        out_rdy = 1'b1;
        step(1'b1, 32'h00001234, 32'hFFFFEDCC, 1'b0, 1'b0);
        chk("t2_lat_k", out_val, 64'd0);
        idle(1);
        chk("t2_lat_k1", out_val, 64'd0);
        idle(1);
        chk("t2_cos_val", out_val, 64'd1);
        chk("t2_cos_data", out_data, 64'h00001234);
        chk("t2_cos_sel", out_sel, 64'd0);
        idle(1);
        chk("t2_sin_val", out_val, 64'd1);
        chk("t2_sin_data", out_data, 64'hFFFFEDCC);
        chk("t2_sin_sel", out_sel, 64'd1);
        idle(1);
        chk("t2_done", out_val, 64'd0);
        chk("t2_model_empty", exp_q.size(), 64'd0);

        // backpressure: 18 pairs, last one dropped
        out_rdy = 1'b0;
        for (int i = 1; i <= 18; i++)
            step(1'b1, N_RES'(32'h100 + i), N_RES'(32'h200 + i), 1'(i == 18), 1'b0);
        chk("t3_level", level, 64'd16);
        chk("t3_full", full, 64'd1);
        chk("t3_drop", drop_cnt, 64'd1);
        chk("t3_head_data", out_data, 64'h101);
        chk("t3_head_val", out_val, 64'd1);
        out_rdy = 1'b1;
        acc0 = n_acc;
        idle(34);
        chk("t3_samples", 64'(n_acc - acc0), 64'd34);
        chk("t3_out_val", out_val, 64'd0);
        chk("t3_empty", empty, 64'd1);
        chk("t3_level_end", level, 64'd0);

        // random backpressure while streaming
        rdy_rand = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, N_RES'(32'hA000 + i * 7), N_RES'(32'hB000 + i * 13), 1'b0, 1'b0);
            idle(3);
        end
        drain();
        rdy_rand = 1'b0;
        out_rdy  = 1'b1;
        chk("t4_samples", 64'(n_acc - acc0), 64'd24);

        // drop counter saturation and clear priority
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("t5_clr", drop_cnt, 64'd0);
        out_rdy = 1'b0;
        for (int i = 1; i <= 17; i++)
            step(1'b1, N_RES'(32'h300 + i), N_RES'(32'h400 + i), 1'b0, 1'b0);
        chk("t5_full", full, 64'd1);
        for (int i = 1; i <= 5; i++)
            step(1'b1, N_RES'(32'h500 + i), N_RES'(32'h600 + i), 1'b1, 1'b0);
        chk("t5_sat", drop_cnt, 64'd3);
        step(1'b1, 32'h777, 32'h888, 1'b1, 1'b0);
        chk("t5_hold", drop_cnt, 64'd3);
        step(1'b1, 32'h999, 32'hAAA, 1'b1, 1'b1);
        chk("t5_clr_drop", drop_cnt, 64'd0);
        chk("t5_level", level, 64'd16);
        out_rdy = 1'b1;
        drain();

        // wrap: 40 pairs every other cycle
        acc0 = n_acc;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, N_RES'(i), N_RES'(1000 + i), 1'b0, 1'b0);
            idle(1);
        end
        drain();
        chk("t6_samples", 64'(n_acc - acc0), 64'd80);
        chk("t6_drop", drop_cnt, 64'd0);

        // reset mid-stream
        out_rdy = 1'b0;
        for (int i = 1; i <= 3; i++)
            step(1'b1, N_RES'(32'hC00 + i), N_RES'(32'hD00 + i), 1'b0, 1'b0);
        chk("t1_pre_val", out_val, 64'd1);
        chk("t1_pre_level", level, 64'd2);
        #3 rst = 1'b0;
        #1;
        chk("t1_out_val", out_val, 64'd0);
        chk("t1_out_data", out_data, 64'd0);
        chk("t1_out_sel", out_sel, 64'd0);
        chk("t1_level", level, 64'd0);
        chk("t1_empty", empty, 64'd1);
        chk("t1_full", full, 64'd0);
        chk("t1_drop", drop_cnt, 64'd0);
        exp_q.delete();
        model_drop = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("t1_no_val", out_val, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
